// File: rtl/dmem_write_buffer_pkg.sv
// Shared definitions for the data-memory write buffer.
// Holds the FSM state encoding, the default buffer depth and the helper
// that sizes the FIFO pointers (the occupancy count is one bit wider).
package dmem_write_buffer_pkg;

  localparam int unsigned DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,  // nothing on the memory bus
    StWrite = 2'd1,  // head entry on the bus
    StRead  = 2'd2,  // load miss on the bus
    StDone  = 2'd3   // captured load data presented to the CPU
  } state_e;

  // Pointer width for a power-of-two depth.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/wbuf_cam.sv
// Posted-write storage with FIFO pointers, occupancy count and an associative
// lookup that returns the youngest entry matching a word address.
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_push, i_push_addr/data   enqueue one {word address, data} entry
//   i_pop                      retire the head entry
//   i_lookup_addr              word address to search for load forwarding
//   o_hit, o_hit_data          youngest matching entry
//   o_head_addr/data           oldest entry
//   o_next_addr/data           entry behind the head (valid when o_multi)
//   o_full, o_empty, o_multi   occupancy == DEPTH, == 0, > 1
module wbuf_cam
  import dmem_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_push,
  input  logic [29:0] i_push_addr,
  input  logic [31:0] i_push_data,
  input  logic        i_pop,
  input  logic [29:0] i_lookup_addr,
  output logic        o_hit,
  output logic [31:0] o_hit_data,
  output logic [29:0] o_head_addr,
  output logic [31:0] o_head_data,
  output logic [29:0] o_next_addr,
  output logic [31:0] o_next_data,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_multi
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [29:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_rptr_nx;
  logic [PW-1:0] w_idx;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: validity comes from the pointers and count.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_addr[r_wptr] <= i_push_addr;
      r_data[r_wptr] <= i_push_data;
    end
  end

  // Scan oldest to youngest so the last match wins. The entry currently on
  // the bus is still counted until it is popped.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_data = '0;
    w_idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rptr + PW'(k);
      if ((CW'(k) < r_count) && (r_addr[w_idx] == i_lookup_addr)) begin
        o_hit      = 1'b1;
        o_hit_data = r_data[w_idx];
      end
    end
  end

  assign w_rptr_nx   = r_rptr + 1'b1;
  assign o_head_addr = r_addr[r_rptr];
  assign o_head_data = r_data[r_rptr];
  assign o_next_addr = r_addr[w_rptr_nx];
  assign o_next_data = r_data[w_rptr_nx];
  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_multi     = (r_count > CW'(1));

endmodule

// File: rtl/dmem_write_buffer.sv
// Data-memory write buffer between a CPU and a single-port memory.
// Stores are posted into a FIFO and retired oldest first; loads forward from
// the youngest matching entry, otherwise the buffer drains and a read is issued.
// Ports:
//   CLK, RST                      clock, asynchronous active-low reset
//   DM_CS, DM_R, DM_W             CPU select / load / store
//   DMEM_ADDR, W_DATA, R_DATA     CPU address, store data, load data
//   STALL                         CPU freeze
//   EMPTY                         no pending writes and no transfer active
//   MEM_REQ, MEM_WE, MEM_ADDR,
//   MEM_WDATA                     registered memory request
//   MEM_ACK, MEM_RDATA            memory completion and read data
module dmem_write_buffer
  import dmem_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        DM_CS,
  input  logic        DM_R,
  input  logic        DM_W,
  input  logic [31:0] DMEM_ADDR,
  input  logic [31:0] W_DATA,
  output logic [31:0] R_DATA,
  output logic        STALL,
  output logic        EMPTY,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA
);

  state_e      r_state, w_state_next;
  logic        r_mem_req, w_mem_req_next;
  logic        r_mem_we, w_mem_we_next;
  logic [31:0] r_mem_addr, w_mem_addr_next;
  logic [31:0] r_mem_wdata, w_mem_wdata_next;
  logic [31:0] r_rdata, w_rdata_next;

  logic        w_load, w_store, w_push, w_pop, w_ack;
  logic        w_hit, w_full, w_empty, w_multi;
  logic [31:0] w_hit_data, w_head_data, w_next_data;
  logic [29:0] w_head_addr, w_next_addr;
  logic        w_unused;

  assign w_unused = ^DMEM_ADDR[1:0];

  // Both DM_R and DM_W high counts as a load.
  assign w_load  = DM_CS & DM_R;
  assign w_store = DM_CS & DM_W & ~DM_R;
  assign w_push  = w_store & ~w_full;
  assign w_ack   = MEM_ACK & r_mem_req;
  assign w_pop   = (r_state == StWrite) & w_ack;

  wbuf_cam #(
    .DEPTH(DEPTH)
  ) u_cam (
    .i_clk         (CLK),
    .i_rst_n       (RST),
    .i_push        (w_push),
    .i_push_addr   (DMEM_ADDR[31:2]),
    .i_push_data   (W_DATA),
    .i_pop         (w_pop),
    .i_lookup_addr (DMEM_ADDR[31:2]),
    .o_hit         (w_hit),
    .o_hit_data    (w_hit_data),
    .o_head_addr   (w_head_addr),
    .o_head_data   (w_head_data),
    .o_next_addr   (w_next_addr),
    .o_next_data   (w_next_data),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_multi       (w_multi)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= StIdle;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_mem_req   <= w_mem_req_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_rdata     <= w_rdata_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_mem_req_next   = r_mem_req;
    w_mem_we_next    = r_mem_we;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_rdata_next     = r_rdata;
    unique case (r_state)
      StIdle: begin
        // Pending writes always go first, so a load miss drains the buffer.
        if (!w_empty) begin
          w_state_next     = StWrite;
          w_mem_req_next   = 1'b1;
          w_mem_we_next    = 1'b1;
          w_mem_addr_next  = {w_head_addr, 2'b00};
          w_mem_wdata_next = w_head_data;
        end else if (w_load && !w_hit) begin
          w_state_next    = StRead;
          w_mem_req_next  = 1'b1;
          w_mem_we_next   = 1'b0;
          w_mem_addr_next = {DMEM_ADDR[31:2], 2'b00};
        end
      end
      StWrite: begin
        if (w_ack) begin
          // Chain straight to the next entry; an entry pushed into a buffer
          // holding only the head is picked up from idle instead.
          if (w_multi) begin
            w_mem_addr_next  = {w_next_addr, 2'b00};
            w_mem_wdata_next = w_next_data;
          end else begin
            w_state_next   = StIdle;
            w_mem_req_next = 1'b0;
            w_mem_we_next  = 1'b0;
          end
        end
      end
      StRead: begin
        if (w_ack) begin
          w_state_next   = StDone;
          w_mem_req_next = 1'b0;
          w_rdata_next   = MEM_RDATA;
        end
      end
      StDone: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  assign STALL     = (w_store & w_full) | (w_load & ~w_hit & (r_state != StDone));
  assign R_DATA    = (w_load & w_hit) ? w_hit_data : r_rdata;
  assign EMPTY     = w_empty & ~r_mem_req;
  assign MEM_REQ   = r_mem_req;
  assign MEM_WE    = r_mem_we;
  assign MEM_ADDR  = r_mem_addr;
  assign MEM_WDATA = r_mem_wdata;

endmodule

// File: doc/dmem_write_buffer.md
DMEM_WRITE_BUFFER -- requirements
Module: dmem_write_buffer

Interface
REQ-001 Parameter: DEPTH, 4, number of posted-write entries (power of two, 2..16).
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 DM_CS  input  1  CPU data-memory select.
REQ-005 DM_R  input  1  CPU load request (qualified by DM_CS).
REQ-006 DM_W  input  1  CPU store request (qualified by DM_CS).
REQ-007 DMEM_ADDR  input  32  CPU byte address; bits [1:0] ignored.
REQ-008 W_DATA  input  32  CPU store data.
REQ-009 R_DATA  output  32  load data returned to CPU.
REQ-010 STALL  output  1  freezes the CPU PC and holds its DM_* inputs stable.
REQ-011 EMPTY  output  1  high when no posted writes are pending and no memory transfer is active.
REQ-012 MEM_REQ, MEM_WE  output  1 each  memory request, write-enable.
REQ-013 MEM_ADDR, MEM_WDATA  output  32 each  word-aligned address ([1:0]=00), write data.
REQ-014 MEM_ACK  input  1  memory completes the current transfer in the cycle it is sampled high.
REQ-015 MEM_RDATA  input  32  read data, valid when MEM_ACK is high with MEM_WE low.

Function
REQ-016 The buffer SHALL hold up to DEPTH {word address, data} entries in FIFO order, retiring them to memory oldest first.
REQ-017 A store (DM_CS & DM_W) with the buffer not full SHALL be enqueued at the clock edge, with STALL low and zero-cycle CPU latency.
REQ-018 A store while full SHALL assert STALL combinationally; enqueue occurs on the first edge at which the buffer is not full at cycle start.
REQ-019 A load (DM_CS & DM_R) whose word address matches any entry SHALL return the youngest matching entry's data on R_DATA in the same cycle, with STALL low.
REQ-020 A load miss SHALL assert STALL, drain every pending write, then issue one read; on MEM_ACK, R_DATA is registered, and in the following cycle STALL is low and R_DATA holds the captured value (a single done cycle, with no re-issue).
REQ-021 FSM states: IDLE, WRITE (head entry on the bus), READ (load miss on the bus), DONE (load data presented).
REQ-022 Transitions:
- IDLE->WRITE when non-empty.
- IDLE->READ on a load miss with the buffer empty.
- WRITE->WRITE/IDLE on MEM_ACK (head popped).
- READ->DONE on MEM_ACK.
- DONE->IDLE unconditionally.
REQ-023 MEM_REQ, MEM_WE, MEM_ADDR and MEM_WDATA SHALL be registered and held stable from assertion until MEM_ACK is sampled; MEM_REQ drops for at least zero cycles between transfers (back-to-back allowed).
REQ-024 Enqueue and head-pop in the same cycle SHALL both take effect, leaving the count unchanged.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from an occupancy count of width log2(DEPTH)+1.
REQ-026 An entry being transmitted SHALL remain visible for load forwarding until popped.
REQ-027 DM_R and DM_W both high SHALL be treated as a load; DM_CS low SHALL ignore both.
REQ-028 MEM_ACK while MEM_REQ is low SHALL be ignored.

Reset
REQ-029 RST low SHALL immediately clear the pointers and count, set the FSM to IDLE, and drive MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, R_DATA=0, STALL=0, EMPTY=1.
REQ-030 Reset during an active transfer SHALL abandon that transfer and discard all pending writes.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the DEPTH default and the pointer/count width function.
REQ-032 The entry storage and address-match/youngest-hit logic SHALL be one sub-module, wbuf_cam; the FSM and the memory port remain in the top level.

Verification
REQ-033 Three stores to 0x10, 0x14, 0x18, then MEM_ACK held high -> three write transfers in order, EMPTY=1 after the third ack.
REQ-034 Store 0xAAAA to 0x20, then store 0xBBBB to 0x20, then load 0x22 with MEM_ACK low -> R_DATA=0xBBBB in the same cycle, STALL=0.
REQ-035 DEPTH+1 stores with MEM_ACK low -> STALL high on the fifth store; the first ack releases it one cycle later.
REQ-036 One pending store, then load miss at 0x40; memory returns 0x1234 -> write completes before the read request, STALL high through the read ack, then one cycle with STALL=0 and R_DATA=0x1234.
REQ-037 RST low while MEM_REQ is high with two entries pending -> MEM_REQ=0, EMPTY=1 immediately; no further transfers after release.
